user_timer_bank: RTL
====================

# user_timer_bank

Parametrised bank of compare-match timers exposed as a single OBI subordinate in the user domain, selected by the user subordinate demux. It is the first user-domain subordinate that drives the per-timer `irq_o` interrupt lines toward the core interrupt inputs. Each channel counts prescaled `clk_i` ticks and raises a sticky pending flag on compare match. Channels run in one-shot or auto-reload mode.

## Interface
- `NumTimers`, 4, number of timer channels; legal range 1..16.
- `CntWidth`, 32, counter/compare width; legal range 1..32; register bits above it read 0.
- `PrescWidth`, 8, global prescaler width; legal range 1..32.
- `IdWidth`, 1, OBI transaction ID width.
---
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `req_i`, in, 1: OBI request.
- `gnt_o`, out, 1: grant; tied to 1.
- `addr_i`, in, 32: byte address; only bits [8:2] decoded.
- `we_i`, in, 1: write enable.
- `be_i`, in, 4: byte enables, honoured on writes.
- `wdata_i`, in, 32: write data.
- `aid_i`, in, IdWidth: request ID.
- `rvalid_o`, out, 1: response valid.
- `rdata_o`, out, 32: read data.
- `err_o`, out, 1: response error.
- `rid_o`, out, IdWidth: response ID (= captured `aid_i`).
- `irq_o`, out, NumTimers: level interrupt per channel.

## Operation
- Register map, channel i at offset 0x10·i:
  - +0x0 CTRL: bit0 EN, bit1 RELOAD, bit2 IRQEN.
  - +0x4 COUNT.
  - +0x8 CMP.
  - +0xC STATUS: bit0 PEND, write-1-to-clear.
- Offset 0x100 is PRESC (global).
- Any other offset is out of range, including channel offsets ≥ NumTimers. Out-of-range reads and writes return `err_o`=1 and `rdata_o`=0, and change no state.
- Prescaler counter `pc`:
  - Counts 0..PRESC, then wraps to 0.
  - `tick` is asserted while `pc`==PRESC, so PRESC=0 gives a tick every cycle.
  - A write to PRESC also clears `pc`.
- Per channel, on `tick` with EN=1:
  - If COUNT==CMP: set PEND. If RELOAD=1, COUNT←0. Otherwise COUNT holds and EN←0 (one-shot).
  - Else COUNT←COUNT+1, modulo 2^CntWidth. Wrap-around does not set PEND.
- `irq_o[i]` = PEND_i & IRQEN_i, combinational from flops.
- Simultaneous events:
  - A software write to COUNT or CTRL in the same cycle as a hardware update takes precedence.
  - A hardware PEND set takes precedence over a same-cycle W1C.
- Byte enables: only bytes with `be_i` set are written. STATUS W1C applies only when `be_i[0]`=1.
- Reset values: every register is 0, `pc`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `rid_o`=0, `irq_o`=0.

## Timing
- `gnt_o`=1 at all times; a request is accepted in every cycle where `req_i`=1.
- Response latency is fixed at 1 cycle: `rvalid_o`, `rdata_o`, `err_o` and `rid_o` are registered, valid the cycle after acceptance, and held for exactly one cycle.
- Back-to-back requests give back-to-back responses, so at most 1 transaction is outstanding.
- `rdata_o`=0 on writes and whenever `rvalid_o`=0.
- Write effect:
  - Register state updates on the acceptance edge, so a read issued in the next cycle returns the new value.
  - `irq_o` reflects a W1C one cycle after acceptance.
- Counter effect:
  - COUNT update is visible 1 cycle after a `tick` cycle.
  - PEND sets on the edge ending the matching `tick` cycle, and `irq_o` rises the same cycle PEND is visible.
- Reset asserted mid-transaction: the pending response is dropped and all outputs return to reset values asynchronously.

## Test plan
- Reset, then read all registers: every read returns 0 with `err_o`=0, `rid_o` equals the request ID, `rvalid_o` asserted 1 cycle after `req_i`.
- Ch0: CMP=3, PRESC=0, CTRL=0b111. PEND and `irq_o[0]` rise 4 cycles after EN is visible. COUNT then reads 0,1,2,3,0 with a period of 4.
- Ch1: one-shot, CMP=2, PRESC=2. Match occurs after 9 cycles, EN reads 0, COUNT holds at 2. A W1C to STATUS clears `irq_o[1]` the next cycle.
- PEND W1C issued in the same cycle as a new match: PEND remains 1. A COUNT write of 0x10 in a `tick` cycle reads back 0x10.
- With NumTimers=4, read offset 0x40 and write 0x104: both return `err_o`=1 and `rdata_o`=0, and no register changes.
- Write CMP=0xAABBCCDD with `be_i`=0b0010 over a reset CMP: it reads back 0x0000CC00. Assert `rst_i` during an outstanding read: `rvalid_o` drops to 0 immediately.

Source files
------------

// File: rtl/user_timer_bank.sv
// Bank of prescaled compare-match timers behind an OBI subordinate port.
// Each channel raises a sticky pending flag on match; irq_o = PEND & IRQEN.
module user_timer_bank #(
  parameter int unsigned NumTimers  = 4,
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned PrescWidth = 8,
  parameter int unsigned IdWidth    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic [NumTimers-1:0] irq_o
);

  function automatic logic [31:0] bmerge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  logic [NumTimers-1:0] en_q, en_d;
  logic [NumTimers-1:0] rld_q, rld_d;
  logic [NumTimers-1:0] ie_q, ie_d;
  logic [NumTimers-1:0] pend_q, pend_d;
  logic [CntWidth-1:0]  cnt_q [NumTimers];
  logic [CntWidth-1:0]  cnt_d [NumTimers];
  logic [CntWidth-1:0]  cmp_q [NumTimers];
  logic [CntWidth-1:0]  cmp_d [NumTimers];

  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [PrescWidth-1:0] pc_q, pc_d;

  logic               rvalid_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [IdWidth-1:0] rid_q;

  logic [NumTimers-1:0] ch_sel;
  logic [NumTimers-1:0] match;
  logic                 presc_sel;
  logic                 hit;
  logic                 tick;
  logic [1:0]           reg_idx;
  logic [31:0]          rd_val;
  logic                 unused_addr;

  assign unused_addr = ^{addr_i[31:9], addr_i[1:0]};

  assign reg_idx   = addr_i[3:2];
  assign presc_sel = addr_i[8] & (addr_i[7:2] == 6'd0);
  assign tick      = (pc_q == presc_q);

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NumTimers; i++) begin
      ch_sel[i] = ~addr_i[8] & (addr_i[7:4] == 4'(i));
    end
  end

  assign hit = presc_sel | (|ch_sel);

  always_comb begin
    rd_val = '0;
    if (presc_sel) rd_val = 32'(presc_q);
    for (int i = 0; i < NumTimers; i++) begin
      if (ch_sel[i]) begin
        case (reg_idx)
          2'd0:    rd_val = {29'd0, ie_q[i], rld_q[i], en_q[i]};
          2'd1:    rd_val = 32'(cnt_q[i]);
          2'd2:    rd_val = 32'(cmp_q[i]);
          default: rd_val = {31'd0, pend_q[i]};
        endcase
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    pc_d    = tick ? '0 : pc_q + PrescWidth'(1);
    if (req_i && we_i && presc_sel) begin
      presc_d = PrescWidth'(bmerge(32'(presc_q), wdata_i, be_i));
      pc_d    = '0;
    end
  end

  // Hardware update first; software writes then override it,
  // except that a hardware PEND set beats a same-cycle clear.
  always_comb begin
    en_d   = en_q;
    rld_d  = rld_q;
    ie_d   = ie_q;
    pend_d = pend_q;
    match  = '0;
    for (int i = 0; i < NumTimers; i++) begin
      cnt_d[i] = cnt_q[i];
      cmp_d[i] = cmp_q[i];
      if (tick && en_q[i]) begin
        if (cnt_q[i] == cmp_q[i]) begin
          match[i] = 1'b1;
          if (rld_q[i]) cnt_d[i] = '0;
          else          en_d[i]  = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end
      end
      if (req_i && we_i && ch_sel[i]) begin
        case (reg_idx)
          2'd0: begin
            if (be_i[0]) begin
              en_d[i]  = wdata_i[0];
              rld_d[i] = wdata_i[1];
              ie_d[i]  = wdata_i[2];
            end
          end
          2'd1: cnt_d[i] = CntWidth'(bmerge(32'(cnt_q[i]), wdata_i, be_i));
          2'd2: cmp_d[i] = CntWidth'(bmerge(32'(cmp_q[i]), wdata_i, be_i));
          default: begin
            if (be_i[0] && wdata_i[0]) pend_d[i] = 1'b0;
          end
        endcase
      end
      if (match[i]) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q    <= '0;
      rld_q   <= '0;
      ie_q    <= '0;
      pend_q  <= '0;
      presc_q <= '0;
      pc_q    <= '0;
      for (int i = 0; i < NumTimers; i++) begin
        cnt_q[i] <= '0;
        cmp_q[i] <= '0;
      end
    end else begin
      en_q    <= en_d;
      rld_q   <= rld_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i & ~hit;
      rdata_q  <= (req_i && !we_i && hit) ? rd_val : '0;
      rid_q    <= req_i ? aid_i : '0;
    end
  end

  assign gnt_o    = 1'b1;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign irq_o    = pend_q & ie_q;

endmodule
